gray_packer: RTL and testbench
==============================

GRAY_PACKER -- requirements
Module: gray_packer

Interface
REQ-001 Parameter DIN_W, default 8: width of one input lane, legal range 2..32.
REQ-002 Parameter RATIO, default 4: input beats packed per output word, legal range 2..16.
REQ-003 Parameter GRAY_EN, default 1: 1 = each lane binary-to-Gray encoded before packing; 0 = lanes passed unchanged.
REQ-004 Parameter MSB_FIRST, default 1: 1 = first accepted beat lands in the most significant lane; 0 = first beat lands in lane 0 (LSBs).
REQ-005 Parameter SEQ_W, default 8: width of the output word sequence counter.
REQ-006 clk  input  1  single clock; all logic is rising-edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 din_valid  input  1  data_in carries a beat this cycle.
REQ-009 data_in  input  DIN_W  input lane value, binary.
REQ-010 flush  input  1  single-cycle request to emit any partial word.
REQ-011 data_out  output  DIN_W*RATIO  packed word; registered; held between emissions.
REQ-012 clk1x_en  output  1  one-cycle strobe marking a new data_out.
REQ-013 lanes  output  $clog2(RATIO+1)  count of valid lanes in the current data_out.
REQ-014 seq_gray  output  SEQ_W  Gray-coded count of words emitted since reset.
REQ-015 busy  output  1  high while a partial word is held (fill count nonzero).

Function
REQ-016 A beat is accepted on every rising clk edge with din_valid=1; no backpressure exists and no beat is ever dropped.
REQ-017 Lane value = GRAY_EN ? (data_in ^ (data_in >> 1)) : data_in, computed on the accepted beat.
REQ-018 A fill counter 0..RATIO-1 selects the lane for each accepted beat; lane order follows MSB_FIRST.
REQ-019 States: FILL (counting beats) and EMIT (one-cycle strobe); EMIT is entered after the RATIO-th beat or on a flush with fill count nonzero, then returns to FILL.
REQ-020 Full word: the cycle after the RATIO-th beat is accepted, data_out = the packed word, lanes = RATIO, clk1x_en = 1 for exactly one cycle; latency is one clock.
REQ-021 The fill counter wraps to 0 on the RATIO-th beat; a beat in the very next cycle starts the next word with no bubble, so back-to-back input yields clk1x_en every RATIO cycles.
REQ-022 Flush with fill count k>0 and din_valid=0: the next cycle emits the partial word, k valid lanes, unfilled lanes zero, lanes = k, clk1x_en = 1; the fill counter clears.
REQ-023 Flush with din_valid=1 in the same cycle: the beat is accepted first, then the word emits with lanes = k+1 (or RATIO if that beat completes it); it never emits twice.
REQ-024 Flush with fill count 0 and din_valid=0: ignored; no strobe, seq_gray unchanged.
REQ-025 seq_gray advances by one Gray step on every strobe and wraps modulo 2^SEQ_W; exactly one bit changes per emission.
REQ-026 data_out, lanes and seq_gray change only on cycles where clk1x_en=1.
REQ-027 busy = 1 exactly when the fill counter is nonzero.

Reset
REQ-028 rst_n low asynchronously forces data_out=0, clk1x_en=0, lanes=0, seq_gray=0, busy=0, fill counter=0, state=FILL.
REQ-029 A partial word held at reset is discarded; after release the first accepted beat goes into the first lane.
REQ-030 Reset asserted in the EMIT cycle drops the strobe immediately; release is synchronised only by the first clk edge.

Verification
REQ-031 Defaults; beats 0x00,0x01,0x02,0x03 back-to-back -> one cycle later data_out=32'h00010302, lanes=4, clk1x_en one cycle, seq_gray=8'h01.
REQ-032 Continuous counting 0x00..0x07 -> strobes 4 cycles apart: 32'h00010302, then 32'h06070504, with seq_gray 8'h01 then 8'h03.
REQ-033 Beats 0x10,0x11, then flush alone -> data_out=32'h18190000, lanes=2, busy drops to 0; a flush alone on the next cycle -> no strobe.
REQ-034 GRAY_EN=0, MSB_FIRST=0; beats 0x00..0x03 -> data_out=32'h03020100; with MSB_FIRST=1 -> 32'h00010203.
REQ-035 rst_n pulsed low after 3 beats -> all outputs 0 at once; next 4 beats 0x04..0x07 -> 32'h06070504 with seq_gray=8'h01.
REQ-036 Run 300 full words -> seq_gray wraps at 256, exactly one bit flips per strobe, and no beat is lost or duplicated (scoreboard).

Source files
------------

// File: rtl/gray_packer.sv
// Purpose: Gray-encode (optional) input lanes and pack RATIO beats into one registered output word.
// Latency: one clock from the completing beat (or flush) to the clk1x_en strobe with the word on data_out.
// Backpressure: none; every din_valid beat is accepted, including beats in the strobe cycle.
module gray_packer #(
  parameter int DIN_W     = 8,
  parameter int RATIO     = 4,
  parameter int GRAY_EN   = 1,
  parameter int MSB_FIRST = 1,
  parameter int SEQ_W     = 8,
  localparam int LANE_W   = $clog2(RATIO + 1),
  localparam int WORD_W   = DIN_W * RATIO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic [DIN_W-1:0]  data_in,
  input  logic              flush,
  output logic [WORD_W-1:0] data_out,
  output logic              clk1x_en,
  output logic [LANE_W-1:0] lanes,
  output logic [SEQ_W-1:0]  seq_gray,
  output logic              busy
);

  typedef enum logic {FILL, EMIT} state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   fill_q;
  logic [LANE_W-1:0]   fill_inc;
  logic [LANE_W-1:0]   lanes_d;
  logic [LANE_W-1:0]   idx;
  logic [WORD_W-1:0]   acc_q;
  logic [WORD_W-1:0]   acc_d;
  logic [DIN_W-1:0]    lane_val;
  logic [SEQ_W-1:0]    seq_bin;
  logic [SEQ_W-1:0]    seq_nx;
  logic                emit;

  // Merge the current beat into the accumulator and decide whether a word leaves this edge.
  always_comb begin
    lane_val = (GRAY_EN != 0) ? (data_in ^ (data_in >> 1)) : data_in;
    idx      = (MSB_FIRST != 0) ? (LANE_W'(RATIO - 1) - fill_q) : fill_q;
    acc_d    = acc_q;
    if (din_valid) begin
      for (int i = 0; i < RATIO; i++) begin
        if (idx == LANE_W'(i)) begin
          acc_d[i*DIN_W +: DIN_W] = lane_val;
        end
      end
    end
    fill_inc = fill_q + LANE_W'(1);
    lanes_d  = din_valid ? fill_inc : fill_q;
    // A flush that coincides with a beat rides on that beat, so it can never emit twice.
    emit     = (din_valid && (fill_inc == LANE_W'(RATIO))) ||
               (flush && (lanes_d != '0));
    state_d  = emit ? EMIT : FILL;
    seq_nx   = seq_bin + SEQ_W'(1);
  end

  // State register: EMIT lasts exactly one cycle and doubles as the output strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill counter, accumulator and the registered output word with its sequence number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q   <= '0;
      acc_q    <= '0;
      data_out <= '0;
      lanes    <= '0;
      seq_bin  <= '0;
      seq_gray <= '0;
    end else if (emit) begin
      // Clearing the accumulator here guarantees unfilled lanes of the next partial word are zero.
      fill_q   <= '0;
      acc_q    <= '0;
      data_out <= acc_d;
      lanes    <= lanes_d;
      seq_bin  <= seq_nx;
      seq_gray <= seq_nx ^ (seq_nx >> 1);
    end else if (din_valid) begin
      fill_q   <= fill_inc;
      acc_q    <= acc_d;
    end
  end

  assign clk1x_en = (state_q == EMIT);
  assign busy     = (fill_q != '0);

endmodule

// File: tb/tb_gray_packer.sv
module tb_gray_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        flush = 1'b0;

  logic [31:0] data_out, data_out_b, data_out_c;
  logic        clk1x_en, clk1x_en_b, clk1x_en_c;
  logic [2:0]  lanes, lanes_b, lanes_c;
  logic [7:0]  seq_gray, seq_gray_b, seq_gray_c;
  logic        busy, busy_b, busy_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_packer dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .data_in(data_in), .flush(flush),
    .data_out(data_out), .clk1x_en(clk1x_en), .lanes(lanes), .seq_gray(seq_gray), .busy(busy)
  );

  gray_packer #(.GRAY_EN(0), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .data_in(data_in), .flush(flush),
    .data_out(data_out_b), .clk1x_en(clk1x_en_b), .lanes(lanes_b), .seq_gray(seq_gray_b), .busy(busy_b)
  );

  gray_packer #(.GRAY_EN(0), .MSB_FIRST(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .data_in(data_in), .flush(flush),
    .data_out(data_out_c), .clk1x_en(clk1x_en_c), .lanes(lanes_c), .seq_gray(seq_gray_c), .busy(busy_c)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a list of beats since the last word; a word is formed from that list.
  logic [7:0]  pend [4];
  int          n_pend = 0;
  int          exp_cnt = 0;
  int          beats_sent = 0;
  logic [31:0] exp_a = '0, exp_b = '0, exp_c = '0;
  int          exp_lanes = 0;
  bit          exp_strobe = 0;

  function automatic logic [31:0] pack(input int n, input bit gray, input bit msb);
    logic [31:0] w;
    logic [7:0]  v;
    int          lane;
    w = '0;
    for (int i = 0; i < n; i++) begin
      v = gray ? (pend[i] ^ (pend[i] >> 1)) : pend[i];
      lane = msb ? (3 - i) : i;
      w[lane*8 +: 8] = v;
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_pend = 0; exp_cnt = 0; beats_sent = 0;
      exp_a = '0; exp_b = '0; exp_c = '0; exp_lanes = 0; exp_strobe = 0;
    end else begin
      exp_strobe = 0;
      if (din_valid) begin
        pend[n_pend] = data_in;
        n_pend++;
        beats_sent++;
      end
      if (n_pend == 4 || (flush && n_pend > 0)) begin
        exp_a = pack(n_pend, 1, 1);
        exp_b = pack(n_pend, 0, 0);
        exp_c = pack(n_pend, 0, 1);
        exp_lanes = n_pend;
        exp_cnt++;
        exp_strobe = 1;
        n_pend = 0;
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  logic [7:0] prev_seq = '0;
  int         lane_sum = 0;
  logic [7:0] cnt8;

  always @(negedge clk) begin
    cnt8 = 8'(exp_cnt);
    chk("data_out",    data_out,          exp_a);
    chk("data_out_b",  data_out_b,        exp_b);
    chk("data_out_c",  data_out_c,        exp_c);
    chk("clk1x_en",    32'(clk1x_en),     32'(exp_strobe));
    chk("clk1x_en_b",  32'(clk1x_en_b),   32'(exp_strobe));
    chk("lanes",       32'(lanes),        32'(exp_lanes));
    chk("seq_gray",    32'(seq_gray),     32'(cnt8 ^ (cnt8 >> 1)));
    chk("busy",        32'(busy),         32'(n_pend != 0));
    if (!rst_n) begin
      prev_seq = '0;
      lane_sum = 0;
    end else if (clk1x_en) begin
      chk("seq_one_bit", 32'($countones(seq_gray ^ prev_seq)), 32'd1);
      prev_seq = seq_gray;
      lane_sum += int'(lanes);
    end
  end

  task automatic drive(input bit v, input logic [7:0] d, input bit f);
    din_valid = v; data_in = d; flush = f;
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_lanes", 32'(lanes), 32'd0);
    chk("rst_seq", 32'(seq_gray), 32'h0);
    chk("rst_strobe", 32'(clk1x_en), 32'd0);
    rst_n = 1'b1;

    // Counting beats 0..7 back to back.
    for (int i = 0; i < 4; i++) drive(1, 8'(i), 0);
    chk("w0_data", data_out, 32'h00010302);
    chk("w0_lanes", 32'(lanes), 32'd4);
    chk("w0_strobe", 32'(clk1x_en), 32'd1);
    chk("w0_seq", 32'(seq_gray), 32'h01);
    chk("w0_bin_lsb", data_out_b, 32'h03020100);
    chk("w0_bin_msb", data_out_c, 32'h00010203);
    for (int i = 4; i < 8; i++) begin
      drive(1, 8'(i), 0);
      if (i == 4) chk("w0_strobe_one_cycle", 32'(clk1x_en), 32'd0);
    end
    chk("w1_data", data_out, 32'h06070504);
    chk("w1_seq", 32'(seq_gray), 32'h03);
    drive(0, 8'h00, 0);

    // Partial word by a lone flush, then a flush with nothing held.
    drive(1, 8'h10, 0);
    drive(1, 8'h11, 0);
    chk("p_busy", 32'(busy), 32'd1);
    drive(0, 8'h00, 1);
    chk("p_data", data_out, 32'h18190000);
    chk("p_lanes", 32'(lanes), 32'd2);
    chk("p_busy_clr", 32'(busy), 32'd0);
    drive(0, 8'h00, 1);
    chk("p_no_strobe", 32'(clk1x_en), 32'd0);
    chk("p_seq_hold", 32'(seq_gray), 32'h02);

    // Flush arriving together with a beat.
    drive(1, 8'h20, 0);
    drive(1, 8'h21, 1);
    chk("fb_data", data_out, 32'h30310000);
    chk("fb_lanes", 32'(lanes), 32'd2);
    drive(0, 8'h00, 0);

    // Reset with a partial word held.
    for (int i = 1; i < 4; i++) drive(1, 8'(i), 0);
    din_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("ar_data", data_out, 32'h0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_seq", 32'(seq_gray), 32'h0);
    release_reset();
    for (int i = 4; i < 8; i++) drive(1, 8'(i), 0);
    chk("ar_word", data_out, 32'h06070504);
    chk("ar_word_seq", 32'(seq_gray), 32'h01);

    // Reset landing in the strobe cycle.
    for (int i = 0; i < 4; i++) drive(1, 8'(i), 0);
    din_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("re_strobe", 32'(clk1x_en), 32'd0);
    chk("re_lanes", 32'(lanes), 32'd0);
    release_reset();

    // 300 back-to-back words, crossing the sequence wrap.
    for (int i = 0; i < 1200; i++) drive(1, 8'($urandom), 0);
    chk("wrap_seq", 32'(seq_gray), 32'(8'(300) ^ (8'(300) >> 1)));

    // Random valid/flush mix.
    for (int i = 0; i < 800; i++)
      drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 12) == 0);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
    chk("beats_conserved", 32'(lane_sum), 32'(beats_sent));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
